// File: rtl/ifetch_unit_if.sv
// Signal bundle between the fetch unit, the PC/decode stages and instruction memory.
// The master modport is the fetch unit; slave is the surrounding pipeline and memory.
interface ifetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] pc_in;
    logic              fetch_req;
    logic              fetch_ready;
    logic              flush;
    logic [DATA_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              misalign_err;
    logic              bus_err;

    modport master (
        input  pc_in, fetch_req, flush, inst_ready, mem_rdata, mem_ack,
        output fetch_ready, inst_out, inst_pc, inst_valid, mem_addr, mem_rd,
               misalign_err, bus_err
    );

    modport slave (
        output pc_in, fetch_req, flush, inst_ready, mem_rdata, mem_ack,
        input  fetch_ready, inst_out, inst_pc, inst_valid, mem_addr, mem_rd,
               misalign_err, bus_err
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch controller: one req/ack memory read per fetch, result handed to
// decode over valid/ready, with flush, misaligned-PC and timeout handling.
module ifetch_unit #(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input logic           clk,
    input logic           rst,
    ifetch_unit_if.master bus
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DROP,
        ST_HOLD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    assign timeout_hit     = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign bus.fetch_ready = (state == ST_IDLE);

    // NOTE: every register here is assigned with <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            wait_cnt         <= '0;
            bus.mem_rd       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.inst_valid   <= 1'b0;
            bus.inst_out     <= DATA_W'(NOP_INST);
            bus.inst_pc      <= '0;
            bus.misalign_err <= 1'b0;
            bus.bus_err      <= 1'b0;
        end else begin
            bus.misalign_err <= 1'b0;
            bus.bus_err      <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.fetch_req && !bus.flush) begin
                        if (bus.pc_in[1:0] != 2'b00) begin
                            bus.misalign_err <= 1'b1;
                        end else begin
                            bus.mem_addr <= bus.pc_in;
                            bus.mem_rd   <= 1'b1;
                            wait_cnt     <= '0;
                            state        <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (bus.mem_ack) begin
                        bus.mem_rd <= 1'b0;
                        if (bus.flush) begin
                            state <= ST_IDLE;
                        end else begin
                            bus.inst_out   <= bus.mem_rdata;
                            bus.inst_pc    <= bus.mem_addr;
                            bus.inst_valid <= 1'b1;
                            state          <= ST_HOLD;
                        end
                    end else if (timeout_hit) begin
                        bus.bus_err <= 1'b1;
                        bus.mem_rd  <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (bus.flush) begin
                        // The read cannot be withdrawn, so keep mem_rd up and discard the data.
                        state <= ST_DROP;
                    end
                end

                ST_DROP: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (bus.mem_ack) begin
                        bus.mem_rd <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (timeout_hit) begin
                        bus.bus_err <= 1'b1;
                        bus.mem_rd  <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end

                ST_HOLD: begin
                    if (bus.inst_ready || bus.flush) begin
                        bus.inst_valid <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
